rgmii_speed_scan_ctrl: RTL
==========================

# rgmii_speed_scan_ctrl

Round-robin scheduler that shares one RGMII receive-clock measurement engine among `NUM_PORTS` Ethernet ports. For each port it:

- selects the port's rx clock into the engine;
- clears the engine, lets it settle, and triggers a measurement window;
- classifies the returned count as a link speed and debounces it;
- publishes per-port speed and link-valid flags to the MAC/RGMII datapath configuration.

All logic runs in the `sys_clk` domain. The engine owns all rx-clock-domain logic.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of scanned ports, 2..16.
- `PSEL_W`, 2: `port_sel` width, equal to clog2(`NUM_PORTS`).
- `CNT_W`, 7: `meas_count` width.
- `SETTLE_CYC`, 64: cycles `meas_clr` is held after a port change, 1..255.
- `MEAS_TIMEOUT`, 200: cycles allowed in WAIT before a measurement is declared no-clock, 1..1023.
- `DEBOUNCE`, 3: consecutive agreeing classifications required to commit a speed, 1..7.
- `TH_100`, 40: `meas_count` <= `TH_100` classifies as 100M or slower.
- `TH_10`, 6: `meas_count` <= `TH_10` classifies as 10M (only with the `_EN` macro).

Ports (clock and reset first):
- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  scan enable, level.
- `port_sel`  out  `PSEL_W`  engine clock-mux select.
- `meas_clr`  out  1  engine clear, level.
- `meas_start`  out  1  engine start, one-cycle pulse.
- `meas_done`  in  1  engine result-valid pulse.
- `meas_count`  in  `CNT_W`  engine result, valid with `meas_done`.
- `speed`  out  2*`NUM_PORTS`  per-port speed; port p occupies bits [2p+1:2p].
  - 00 = 1000M, 01 = 100M, 10 = 10M, 11 = no clock.
- `link_valid`  out  `NUM_PORTS`  per-port committed-speed-is-valid flag.
- `speed_chg`  out  1  one-cycle pulse when a port's {`speed`, `link_valid`} changes.
- `chg_port`  out  `PSEL_W`  index of the changed port, valid with `speed_chg`.

## Operation
State machine: IDLE, SELECT, START, WAIT, EVAL, NEXT.
- **IDLE:**
  - Go to SELECT when `enable`=1.
  - `meas_clr`=1 while in IDLE.
- **SELECT:**
  - `port_sel` holds the current port; `meas_clr`=1.
  - Stay for exactly `SETTLE_CYC` cycles, then go to START.
- **START:**
  - `meas_clr`=0, `meas_start`=1 for one cycle.
  - Load the timeout counter; go to WAIT.
- **WAIT:**
  - On `meas_done`=1, capture `meas_count` and go to EVAL.
  - If the timeout counter reaches `MEAS_TIMEOUT` first, the classification is 11 (no clock); go to EVAL.
  - If `meas_done` and the timeout occur in the same cycle, `meas_done` wins.
- **EVAL** (one cycle), classify the result:
  - count > `TH_100` → 00;
  - count <= `TH_100` → 01;
  - count <= `TH_10` → 10 (with macro only).
- Debounce state per port: a candidate code and a 3-bit agree counter.
  - If `link_valid[p]`=1 and classification == `speed[p]`: clear the agree counter.
  - Otherwise, if classification == candidate: increment the agree counter, saturating at 7.
  - Otherwise: candidate ← classification, agree counter ← 1.
  - Commit when the agree counter reaches `DEBOUNCE`:
    - `speed[p]` ← candidate;
    - `link_valid[p]` ← (candidate != 11);
    - clear the agree counter;
    - pulse `speed_chg` with `chg_port`=p if {`speed[p]`, `link_valid[p]`} changed.
- **NEXT:**
  - Advance the port: p+1, wrapping from `NUM_PORTS`-1 to 0.
  - Go to SELECT if `enable`=1, else IDLE.
  - Dropping `enable` mid-round finishes the current port through EVAL first.
- `meas_done` outside WAIT is ignored.

## Timing
Reset values:
- state IDLE, port 0;
- `port_sel`=0, `meas_clr`=1, `meas_start`=0;
- `speed` all 00, `link_valid` all 0;
- `speed_chg`=0, `chg_port`=0;
- candidates 00, agree counters 0.

Cycle-level rules:
- All outputs are registered.
- `port_sel` changes only on the NEXT→SELECT/IDLE transition, never while `meas_clr`=0.
- `meas_start` rises exactly `SETTLE_CYC` cycles after SELECT entry.
- `speed`, `link_valid` and `speed_chg` update on the cycle after EVAL.
- Per-port period with immediate `meas_done`: `SETTLE_CYC` + 4 cycles plus the engine latency.
- Reset asserted mid-scan: everything returns to reset values immediately. No `meas_start` may be emitted during reset.

## Configuration
`SPEED_SCAN_10M_EN`:
- Defined: three-way classification including 10M (code 10).
- Undefined: the `TH_10` comparison is removed, so code 10 is never produced and the classifier is two-way (00/01, plus 11 on timeout).

## Test plan
- **Reset default:** reset release with `enable`=0 → `speed`=0, `link_valid`=0, `meas_clr`=1, no `meas_start` over 1000 cycles.
- **Single-port detection:** `NUM_PORTS`=4, engine returns count 100 for port 0 and 20 for the others, `DEBOUNCE`=3 → after 3 rounds `speed`=8'b01_01_01_00, `link_valid`=4'hF, four `speed_chg` pulses (`chg_port` 0,1,2,3).
- **Debounce reset:** port 1 sees 20, 20, 100, 20, 20, 20 → exactly one commit, to 01, on the 6th sample of port 1.
- **No clock:** `meas_done` never asserted for port 2 → each WAIT lasts exactly `MEAS_TIMEOUT` cycles; after 3 rounds `speed[5:4]`=11, `link_valid[2]`=0.
- **Simultaneous done and timeout:** `meas_done` with count 50 on the timeout cycle → classified 00, not 11.
- **10M with macro:** macro defined, count 3 → 10; macro undefined, same stimulus → 01.

Source files
------------

// File: rtl/rgmii_speed_scan_ctrl.sv
// rgmii_speed_scan_ctrl: round-robin scheduler that time-shares one RGMII rx-clock
// measurement engine across NUM_PORTS ports, classifies each port's clock count as a
// link speed, debounces it, and publishes per-port speed / link-valid flags.
// Optional feature: define SPEED_SCAN_10M_EN to enable the 10M (code 10) classification.
module rgmii_speed_scan_ctrl #(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned PSEL_W       = 2,
  parameter int unsigned CNT_W        = 7,
  parameter int unsigned SETTLE_CYC   = 64,
  parameter int unsigned MEAS_TIMEOUT = 200,
  parameter int unsigned DEBOUNCE     = 3,
  parameter int unsigned TH_100       = 40,
  parameter int unsigned TH_10        = 6
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   enable,
  output logic [PSEL_W-1:0]      port_sel,
  output logic                   meas_clr,
  output logic                   meas_start,
  input  logic                   meas_done,
  input  logic [CNT_W-1:0]       meas_count,
  output logic [2*NUM_PORTS-1:0] speed,
  output logic [NUM_PORTS-1:0]   link_valid,
  output logic                   speed_chg,
  output logic [PSEL_W-1:0]      chg_port
);

  localparam logic [7:0]        SettleLast = 8'(SETTLE_CYC - 1);
  localparam logic [9:0]        TmoLast    = 10'(MEAS_TIMEOUT);
  localparam logic [2:0]        DebCnt     = 3'(DEBOUNCE);
  localparam logic [CNT_W-1:0]  Th100      = CNT_W'(TH_100);
  localparam logic [PSEL_W-1:0] LastPort   = PSEL_W'(NUM_PORTS - 1);
`ifdef SPEED_SCAN_10M_EN
  localparam logic [CNT_W-1:0]  Th10       = CNT_W'(TH_10);
`endif

  typedef enum logic [2:0] {StIdle, StSelect, StStart, StWait, StEval, StNext} state_e;

  state_e            r_state, w_state_d;
  logic [PSEL_W-1:0] r_port;
  logic [7:0]        r_settle;
  logic [9:0]        r_tmo;
  logic [CNT_W-1:0]  r_count;
  logic              r_noclk;
  logic              r_meas_clr, r_meas_start;
  logic [1:0]        r_spd   [NUM_PORTS];
  logic [1:0]        r_cand  [NUM_PORTS];
  logic [2:0]        r_agree [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_link;
  logic              r_chg;
  logic [PSEL_W-1:0] r_chg_port;

  logic       w_timeout;
  logic [1:0] w_cls;
  logic       w_hit, w_commit, w_changed, w_new_lv;
  logic [1:0] w_cand_n;
  logic [2:0] w_agree_n;

  assign w_timeout = (r_tmo == TmoLast);

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= StIdle;
    else            r_state <= w_state_d;
  end

  // Next-state decode; a done pulse in the timeout cycle still counts as a result.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (enable) w_state_d = StSelect;
      StSelect: if (r_settle == SettleLast) w_state_d = StStart;
      StStart:  w_state_d = StWait;
      StWait:   if (meas_done || w_timeout) w_state_d = StEval;
      StEval:   w_state_d = StNext;
      StNext:   w_state_d = enable ? StSelect : StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Settle/timeout counters, result capture, port advance and registered engine controls.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_port       <= '0;
      r_settle     <= '0;
      r_tmo        <= '0;
      r_count      <= '0;
      r_noclk      <= 1'b0;
      r_meas_clr   <= 1'b1;
      r_meas_start <= 1'b0;
    end else begin
      r_settle     <= (r_state == StSelect) ? r_settle + 8'd1 : 8'd0;
      r_meas_clr   <= (w_state_d inside {StIdle, StSelect, StNext});
      r_meas_start <= (w_state_d == StStart);
      if (r_state == StStart) r_tmo <= 10'd1;
      else if (r_state == StWait && !w_timeout) r_tmo <= r_tmo + 10'd1;
      if (r_state == StWait) begin
        if (meas_done) begin
          r_count <= meas_count;
          r_noclk <= 1'b0;
        end else if (w_timeout) begin
          r_noclk <= 1'b1;
        end
      end
      if (r_state == StNext) r_port <= (r_port == LastPort) ? '0 : r_port + 1'b1;
    end
  end

  // Speed classification of the captured result.
  always_comb begin
    w_cls = 2'b01;
    if (r_noclk) w_cls = 2'b11;
    else if (r_count > Th100) w_cls = 2'b00;
`ifdef SPEED_SCAN_10M_EN
    else if (r_count <= Th10) w_cls = 2'b10;
`endif
  end

  // Per-port debounce update for the port currently being evaluated.
  always_comb begin
    w_hit     = r_link[r_port] && (w_cls == r_spd[r_port]);
    w_cand_n  = r_cand[r_port];
    w_agree_n = r_agree[r_port];
    w_commit  = 1'b0;
    if (w_hit) begin
      w_agree_n = 3'd0;
    end else if (w_cls == r_cand[r_port]) begin
      w_agree_n = (r_agree[r_port] == 3'd7) ? 3'd7 : r_agree[r_port] + 3'd1;
    end else begin
      w_cand_n  = w_cls;
      w_agree_n = 3'd1;
    end
    if (!w_hit && w_agree_n == DebCnt) begin
      w_commit  = 1'b1;
      w_agree_n = 3'd0;
    end
    w_new_lv  = (w_cand_n != 2'b11);
    w_changed = w_commit && ((w_cand_n != r_spd[r_port]) || (w_new_lv != r_link[r_port]));
  end

  // Debounce state and published speed/link registers, written only in EVAL.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_spd[p]   <= 2'b00;
        r_cand[p]  <= 2'b00;
        r_agree[p] <= 3'd0;
      end
      r_link     <= '0;
      r_chg      <= 1'b0;
      r_chg_port <= '0;
    end else begin
      r_chg <= 1'b0;
      if (r_state == StEval) begin
        r_cand[r_port]  <= w_cand_n;
        r_agree[r_port] <= w_agree_n;
        if (w_commit) begin
          r_spd[r_port]  <= w_cand_n;
          r_link[r_port] <= w_new_lv;
        end
        r_chg <= w_changed;
        if (w_changed) r_chg_port <= r_port;
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_speed
    assign speed[2*g +: 2] = r_spd[g];
  end

  assign port_sel   = r_port;
  assign meas_clr   = r_meas_clr;
  assign meas_start = r_meas_start;
  assign link_valid = r_link;
  assign speed_chg  = r_chg;
  assign chg_port   = r_chg_port;

endmodule
